// File: rtl/matriz_controlador_if.sv
// Host command, matrix RAM and matrix ALU signals of the coprocessor sequencer.
// master: the sequencer side; slave: host/RAM/ALU side.
interface matriz_controlador_if #(
  parameter int AW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_opcode;
  logic [7:0]    cmd_scalar;
  logic [AW-1:0] cmd_addr_a;
  logic [AW-1:0] cmd_addr_b;
  logic [AW-1:0] cmd_addr_r;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [39:0]   mem_wdata;
  logic [39:0]   mem_rdata;

  logic [3:0]    alu_opcode;
  logic [7:0]    alu_scalar;
  logic [199:0]  alu_matriz_a;
  logic [199:0]  alu_matriz_b;
  logic          alu_start;
  logic          alu_done;
  logic [199:0]  alu_result;

  logic          busy;
  logic          op_done;
  logic          op_error;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_scalar, cmd_addr_a, cmd_addr_b, cmd_addr_r,
    input  mem_rdata, alu_done, alu_result,
    output cmd_ready, mem_addr, mem_we, mem_wdata,
    output alu_opcode, alu_scalar, alu_matriz_a, alu_matriz_b, alu_start,
    output busy, op_done, op_error
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_scalar, cmd_addr_a, cmd_addr_b, cmd_addr_r,
    output mem_rdata, alu_done, alu_result,
    input  cmd_ready, mem_addr, mem_we, mem_wdata,
    input  alu_opcode, alu_scalar, alu_matriz_a, alu_matriz_b, alu_start,
    input  busy, op_done, op_error
  );
endinterface

// File: rtl/matriz_controlador.sv
// Matrix coprocessor command sequencer: reads operands row by row from RAM,
// runs the ALU start/done handshake and writes the 5x5 result back.
//
// state    | meaning
// IDLE     | ready for a host command
// READ_A   | fetch 5 rows of A (6 cycles, 1-cycle RAM latency)
// READ_B   | fetch 5 rows of B (binary opcodes only)
// WAIT_ALU | alu_start held, waiting for alu_done or timeout
// WRITE    | store 5 result rows at addr_r
// CLEAR    | start low, wait for the ALU to drop done
// FINISH   | op_done pulse
// ERR      | op_error pulse (illegal opcode or timeout)
module matriz_controlador #(
  parameter int AW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  matriz_controlador_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, READ_A, READ_B, WAIT_ALU, WRITE, CLEAR, FINISH, ERR
  } state_t;

  localparam logic [15:0] TMR_INIT = 16'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [2:0]    row_q;
  logic [2:0]    prev_row;
  logic [15:0]   tmr_q;
  logic          timed_out_q;
  logic [3:0]    opcode_q;
  logic [7:0]    scalar_q;
  logic [AW-1:0] addr_a_q, addr_b_q, addr_r_q;
  logic [199:0]  mat_a_q, mat_b_q, res_q;
  logic          accept;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1011: is_legal = 1'b1;
      default:                                                        is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_binary(input logic [3:0] op);
    is_binary = (op == 4'b0011) || (op == 4'b0100) || (op == 4'b0101);
  endfunction

  assign accept   = bus.cmd_valid && (state_q == IDLE);
  assign prev_row = row_q - 3'd1;

  assign bus.cmd_ready    = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.op_done      = (state_q == FINISH);
  assign bus.op_error     = (state_q == ERR);
  assign bus.alu_start    = (state_q == WAIT_ALU);
  assign bus.alu_opcode   = opcode_q;
  assign bus.alu_scalar   = scalar_q;
  assign bus.alu_matriz_a = mat_a_q;
  assign bus.alu_matriz_b = mat_b_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and RAM-side outputs
  always_comb begin
    state_d       = state_q;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = is_legal(bus.cmd_opcode) ? READ_A : ERR;
      end
      READ_A: begin
        if (row_q < 3'd5) bus.mem_addr = addr_a_q + AW'(row_q);
        else              state_d = is_binary(opcode_q) ? READ_B : WAIT_ALU;
      end
      READ_B: begin
        if (row_q < 3'd5) bus.mem_addr = addr_b_q + AW'(row_q);
        else              state_d = WAIT_ALU;
      end
      WAIT_ALU: begin
        if (bus.alu_done)        state_d = WRITE;
        else if (tmr_q == 16'd0) state_d = CLEAR;
      end
      WRITE: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_r_q + AW'(row_q);
        bus.mem_wdata = res_q[row_q*40 +: 40];
        if (row_q == 3'd4) state_d = CLEAR;
      end
      CLEAR: begin
        // A done that never clears is bounded by the same timer and reported as an error.
        if (!bus.alu_done)       state_d = timed_out_q ? ERR : FINISH;
        else if (tmr_q == 16'd0) state_d = ERR;
      end
      FINISH:  state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Row index, down-counting timeout timer and the timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q       <= '0;
      tmr_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      if (state_d != state_q)
        row_q <= '0;
      else if (state_q == READ_A || state_q == READ_B || state_q == WRITE)
        row_q <= row_q + 3'd1;

      if (state_d != state_q)  tmr_q <= TMR_INIT;
      else if (tmr_q != 16'd0) tmr_q <= tmr_q - 16'd1;

      if (accept)
        timed_out_q <= 1'b0;
      else if (state_q == WAIT_ALU && state_d == CLEAR)
        timed_out_q <= 1'b1;
    end
  end

  // Command latch, operand capture and result latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q <= '0;
      scalar_q <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_r_q <= '0;
      mat_a_q  <= '0;
      mat_b_q  <= '0;
      res_q    <= '0;
    end else begin
      if (accept) begin
        opcode_q <= bus.cmd_opcode;
        scalar_q <= bus.cmd_scalar;
        addr_a_q <= bus.cmd_addr_a;
        addr_b_q <= bus.cmd_addr_b;
        addr_r_q <= bus.cmd_addr_r;
        mat_a_q  <= '0;
        mat_b_q  <= '0;
      end
      if (state_q == READ_A && row_q != 3'd0) mat_a_q[prev_row*40 +: 40] <= bus.mem_rdata;
      if (state_q == READ_B && row_q != 3'd0) mat_b_q[prev_row*40 +: 40] <= bus.mem_rdata;
      if (state_q == WAIT_ALU && bus.alu_done) res_q <= bus.alu_result;
    end
  end

endmodule
